// File: rtl/sum_deserializer_if.sv
// Handshake bundle between the serial sum stage, the deserializer and the word consumer.
interface sum_deserializer_if #(
  parameter int N = 128,
  parameter int W = 4
);
  logic [W-1:0] in_digit;
  logic         in_valid;
  logic         in_first;
  logic [N-1:0] out_word;
  logic         out_valid;
  logic         out_ready;
  logic         overflow;
  logic         sync_err;

  modport master (
    output in_digit, in_valid, in_first, out_ready,
    input  out_word, out_valid, overflow, sync_err
  );

  modport slave (
    input  in_digit, in_valid, in_first, out_ready,
    output out_word, out_valid, overflow, sync_err
  );
endinterface

// File: rtl/sum_deserializer.sv
// Reassembles LSB-first W-bit sum digits into N-bit words behind a one-entry output register.
//   state    | meaning
//   IDLE     | waiting for a digit flagged in_first
//   ASSEMBLE | collecting digits 1..D-1 of the current word
module sum_deserializer #(
  parameter int N = 128,
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst,
  sum_deserializer_if.slave  bus
);
  localparam int D  = N / W;
  localparam int CW = $clog2(D);

  typedef enum logic {IDLE, ASSEMBLE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    asm_q, asm_d;
  logic [N-1:0]    out_word_q, out_word_d;
  logic            out_valid_q, out_valid_d;
  logic            overflow_q, overflow_d;
  logic            sync_err_q, sync_err_d;
  logic            pop;
  logic            complete;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      asm_q       <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      sync_err_q  <= sync_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    sync_err_d  = sync_err_q;
    complete    = 1'b0;
    pop         = out_valid_q & bus.out_ready;

    if (bus.in_valid) begin
      if (bus.in_first) begin
        // in_first mid-word abandons the partial word and restarts on this digit
        if (state_q == ASSEMBLE) sync_err_d = 1'b1;
        asm_d[W-1:0] = bus.in_digit;
        cnt_d        = CW'(1);
        state_d      = ASSEMBLE;
      end else if (state_q == IDLE) begin
        sync_err_d = 1'b1;
      end else begin
        for (int k = 0; k < D; k++) begin
          if (cnt_q == CW'(k)) asm_d[k*W +: W] = bus.in_digit;
        end
        if (cnt_q == CW'(D-1)) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    if (complete) begin
      if (!out_valid_q || pop) begin
        out_word_d  = asm_d;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  assign bus.out_word  = out_word_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.sync_err  = sync_err_q;
endmodule

// File: tb/tb_sum_deserializer.sv
// Scoreboard bench for sum_deserializer: digit-queue reference model plus directed and random traffic.
module tb_sum_deserializer;
  localparam int N = 128;
  localparam int W = 4;
  localparam int D = N / W;

  localparam logic [N-1:0] WB = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [N-1:0] W1 = {D{4'h1}};
  localparam logic [N-1:0] W2 = {D{4'h2}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sum_deserializer_if #(.N(N), .W(W)) bus ();
  sum_deserializer #(.N(N), .W(W)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_first = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] dq[$];
  logic [N-1:0] exp_q[$];
  logic         m_valid = 1'b0;
  logic [N-1:0] m_word = '0;
  logic         m_ovf = 1'b0;
  logic         m_serr = 1'b0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: digits of the open frame are kept in a queue and summed into a word when D arrive.
  always @(posedge clk) begin
    logic         pop;
    logic         done;
    logic [N-1:0] w;
    logic [N-1:0] tmp;
    if (!rst_n) begin
      dq.delete();
      m_valid = 1'b0;
      m_word  = '0;
      m_ovf   = 1'b0;
      m_serr  = 1'b0;
    end else begin
      pop  = m_valid && bus.out_ready;
      done = 1'b0;
      w    = '0;
      if (bus.in_valid) begin
        if (bus.in_first) begin
          if (dq.size() != 0) m_serr = 1'b1;
          dq.delete();
          dq.push_back(bus.in_digit);
        end else if (dq.size() == 0) begin
          m_serr = 1'b1;
        end else begin
          dq.push_back(bus.in_digit);
          if (dq.size() == D) begin
            done = 1'b1;
            for (int k = 0; k < D; k++) begin
              tmp = {{(N-W){1'b0}}, dq[k]};
              w = w | (tmp << (k * W));
            end
            dq.delete();
          end
        end
      end
      if (done && m_valid && !pop) begin
        m_ovf = 1'b1;
      end else if (done) begin
        m_valid = 1'b1;
        m_word  = w;
        exp_q.push_back(w);
      end else if (pop) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: compares flags every cycle and the word whenever the consumer takes it.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", N'(bus.out_valid), N'(m_valid));
      chk("overflow", N'(bus.overflow), N'(m_ovf));
      chk("sync_err", N'(bus.sync_err), N'(m_serr));
      if (m_valid) chk("held_word", bus.out_word, m_word);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", N'(1), N'(0));
        end else begin
          chk("popped_word", bus.out_word, exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
    end
  endtask

  task automatic send(input logic [N-1:0] w, input int nd, input int g5, input int g30,
                      input bit rl, input bit rnd);
    for (int k = 0; k < nd; k++) begin
      @(posedge clk); #2;
      if (k == 0) t_first = cyc;
      bus.in_valid = 1'b1;
      bus.in_first = (k == 0) || (rnd && $urandom_range(0, 39) == 0);
      bus.in_digit = w[k*W +: W];
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      if (rl && k == nd - 1) bus.out_ready = 1'b1;
      if (k == 5) idle(g5);
      if (k == 30) idle(g30);
      if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = cyc - t_first;
        return;
      end
    end
    chk("wait_valid_timeout", N'(0), N'(1));
  endtask

  initial begin
    int lat;
    logic [N-1:0] rw;
    bus.in_digit  = '0;
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();
    chk_en = 1'b1;
    chk("rst_out_word", bus.out_word, '0);
    chk("rst_out_valid", N'(bus.out_valid), N'(0));

    // basic and gapped words
    bus.out_ready = 1'b1;
    send(WB, D, 0, 0, 1'b0, 1'b0);
    idle(1);
    wait_valid(lat);
    chk("lat_basic", N'(lat), N'(D));
    chk("basic_word", bus.out_word, WB);
    idle(3);
    send(WB, D, 3, 3, 1'b0, 1'b0);
    idle(1);
    wait_valid(lat);
    chk("lat_gapped", N'(lat), N'(D + 6));
    chk("gapped_word", bus.out_word, WB);
    idle(3);

    // backpressure and overflow
    bus.out_ready = 1'b0;
    send(W1, D, 0, 0, 1'b0, 1'b0);
    send(W2, D, 0, 0, 1'b0, 1'b0);
    idle(2);
    chk("bp_word", bus.out_word, W1);
    chk("bp_overflow", N'(bus.overflow), N'(1));
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    idle(1);
    chk("bp_drained", N'(bus.out_valid), N'(0));

    // pop coincident with completion
    do_reset();
    send(W1, D, 0, 0, 1'b0, 1'b0);
    send(W2, D, 0, 0, 1'b1, 1'b0);
    @(posedge clk); #2;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("simul_word", bus.out_word, W2);
    chk("simul_valid", N'(bus.out_valid), N'(1));
    chk("simul_overflow", N'(bus.overflow), N'(0));
    bus.out_ready = 1'b1;
    idle(2);

    // framing errors
    do_reset();
    @(posedge clk); #2;
    bus.in_valid = 1'b1;
    bus.in_first = 1'b0;
    bus.in_digit = 4'h5;
    send(W1, 10, 0, 0, 1'b0, 1'b0);
    send(WB, D, 0, 0, 1'b0, 1'b0);
    idle(1);
    wait_valid(lat);
    chk("frame_word", bus.out_word, WB);
    chk("frame_sync_err", N'(bus.sync_err), N'(1));
    idle(2);

    // reset mid-word
    send(W2, 18, 0, 0, 1'b0, 1'b0);
    do_reset();
    chk("mid_rst_valid", N'(bus.out_valid), N'(0));
    chk("mid_rst_word", bus.out_word, '0);
    chk("mid_rst_sync_err", N'(bus.sync_err), N'(0));
    send(WB, D, 0, 0, 1'b0, 1'b0);
    idle(1);
    wait_valid(lat);
    chk("fresh_word", bus.out_word, WB);
    idle(2);

    // random traffic with random backpressure and occasional framing glitches
    do_reset();
    for (int n = 0; n < 40; n++) begin
      rw = {$urandom, $urandom, $urandom, $urandom};
      send(rw, D, 0, 0, 1'b0, 1'b1);
    end
    bus.out_ready = 1'b1;
    idle(5);
    chk("drained_queue", N'(exp_q.size()), N'(0));

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sum_deserializer.md
# sum_deserializer

Collects the W-bit result digits that the serial adder emits one per clock, least-significant digit first, and reassembles them into full N-bit sums. It sits directly downstream of the serial sum stage and presents each completed word through a single-entry valid/ready output register. Framing errors and overflow are reported through sticky flags so the consumer can detect lost words.

## Interface
- N, default 128: full operand/result width in bits; must be a multiple of W.
- W, default 4: digit width per clock; N/W must be at least 2.
- D = N/W (derived, 32 by default): digits per word. The digit counter is clog2(D) bits wide.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-low; takes effect on the clk edge while rst==0.
- in_digit  input  W  result digit from the serial adder.
- in_valid  input  1  in_digit is valid this cycle.
- in_first  input  1  qualifies in_digit as digit 0 of a new word; only meaningful while in_valid==1.
- out_word  output  N  assembled sum; digit k occupies bits [k*W +: W].
- out_valid  output  1  out_word holds an unconsumed word.
- out_ready  input  1  consumer accepts out_word this cycle.
- overflow  output  1  sticky; a completed word was dropped because the output register was occupied.
- sync_err  output  1  sticky; framing violation detected.

## Operation
- State:
  - assembly register asm[N-1:0];
  - digit counter cnt;
  - busy flag, set while a word is being assembled;
  - output register out_word and out_valid;
  - two sticky flags.
- Accepted digit: any cycle with in_valid==1. Gaps with in_valid==0 hold all state unchanged.
- IDLE (busy==0):
  - in_valid & in_first: write the digit to asm[0 +: W]; set cnt=1, busy=1.
  - in_valid & !in_first: digit is discarded and sync_err is set.
- ASSEMBLE (busy==1):
  - in_valid & !in_first: write the digit to asm[cnt*W +: W] and increment cnt.
  - in_valid & in_first: partial word is abandoned and sync_err is set. The digit is taken as digit 0 of a new word (cnt=1, asm[0 +: W] written).
- Completion: the accepted digit has cnt==D-1.
  - The full word (the previously assembled digits plus this digit) is transferred to out_word on the same edge.
  - out_valid is set, busy is cleared and cnt returns to 0.
- Output register:
  - Pop happens when out_valid & out_ready; out_valid clears on that edge unless a completion also occurs on that edge.
  - Completion while out_valid==1 with no pop on that edge: the new word is discarded, out_word is unchanged, overflow is set, and the assembler still returns to IDLE.
  - Completion and pop on the same edge: the new word replaces the old one, out_valid stays 1, and no overflow is flagged.
- Sticky flags clear only on reset.
- Reset (rst==0 at an edge) applies regardless of any in-flight word:
  - out_word=0, out_valid=0, overflow=0, sync_err=0;
  - cnt=0, busy=0, asm=0.
  - Inputs sampled on that edge are ignored, so a partially assembled word is lost.
- The bits of asm above the current cnt are don't-care internally. However, out_word must contain exactly the D digits accepted for that word.

## Timing
- Digit accept to register update: 1 edge.
- Last digit accepted at edge t: out_valid==1 and out_word is valid immediately after edge t. Minimum 0-cycle added latency relative to the adder's registered digit.
- Minimum word period: D cycles (back-to-back words with in_valid held high). This sustains full throughput when the consumer pops at least once every D cycles.
- out_ready is combinationally unused except at the edge; out_valid does not depend combinationally on out_ready.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic word:
  - Stimulus: reset, then feed 32 digits of 0x0123456789ABCDEF_FEDCBA9876543210 LSB-first, in_first on digit 0 (0x0), out_ready=1.
  - Required response: out_valid pulses for 1 cycle, the edge after digit 31 is accepted, with that exact out_word; overflow=sync_err=0.
- Gapped input:
  - Stimulus: same word with in_valid deasserted for 3 cycles after digits 5 and 30.
  - Required response: identical out_word; completion occurs 6 cycles later than the ungapped run.
- Backpressure/overflow:
  - Stimulus: out_ready=0, two back-to-back words 0x1…1 then 0x2…2.
  - Required response: out_word stays 0x111…1, overflow=1 after the second completion. Raising out_ready then gives one pop and out_valid=0.
- Simultaneous pop and completion:
  - Stimulus: out_ready pulses exactly on the edge the second word completes.
  - Required response: out_word=0x222…2, out_valid stays 1, overflow=0.
- Framing errors:
  - Stimulus: a valid digit with in_first=0 while idle, then in_first reasserted at digit 10 of a word.
  - Required response: sync_err=1. The stray digit is dropped, and the word restarting at the second in_first completes correctly 32 digits later.
- Reset mid-word:
  - Stimulus: rst=0 for one cycle after digit 17, then a fresh full word.
  - Required response: all outputs 0 after the reset edge, and only the fresh word is emitted, intact.
